ahb_framebuffer: RTL

- AHB-Lite slave framebuffer for the M0 display subsystem, parametrised in resolution and bits per pixel.
- Pixels are packed into 32-bit words with full byte-lane write support and readback.
- A hardware fill engine clears or paints the whole frame.
- An independent video read port returns the pixel at (pixel_x, pixel_y) with fixed latency.

---
 rtl/ahb_framebuffer_if.sv | 24 ++
 rtl/ahb_framebuffer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_framebuffer_if.sv
// AHB-Lite bus bundle for the framebuffer slave.
// master: drives address/control/write data and the bus HREADY.
// slave : returns HRDATA and HREADYOUT.
interface ahb_framebuffer_if;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HADDR, HWDATA, HSIZE, HTRANS, HWRITE, HREADY, HSEL,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HADDR, HWDATA, HSIZE, HTRANS, HWRITE, HREADY, HSEL,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/ahb_framebuffer.sv
// AHB-Lite framebuffer slave with a hardware fill engine and a video read port.
//
// Ports:
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   bus             AHB-Lite slave (HADDR[23]: 0 = registers, 1 = pixel memory;
//                   HADDR[22:2] = word index)
//   pixel_x/pixel_y video coordinates
//   pixel           pixel value at the coordinates, 2-cycle latency, 0 out of range
//   fill_busy       fill engine is writing the frame
//
// Registers (word offsets, aliased over the register region):
//   0x0 CTRL      W  bit0 start fill, bit1 clear DONE (reads 0)
//   0x4 COLOUR    RW [BPP-1:0]
//   0x8 STATUS    RO bit0 BUSY, bit1 DONE
//   0xC FILLCOUNT RO current fill word index
//
// BPP must be 1, 2, 4 or 8, and H_RES*V_RES a multiple of 32/BPP.
module ahb_framebuffer #(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480,
  parameter int unsigned BPP   = 1,
  localparam int unsigned XW   = $clog2(H_RES),
  localparam int unsigned YW   = $clog2(V_RES)
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_framebuffer_if.slave bus,
  input  logic [XW-1:0]    pixel_x,
  input  logic [YW-1:0]    pixel_y,
  output logic [BPP-1:0]   pixel,
  output logic             fill_busy
);

  localparam int unsigned PPW   = 32 / BPP;
  localparam int unsigned DEPTH = H_RES * V_RES / PPW;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned OW    = $clog2(PPW);

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  // Pixel storage; intentionally not reset.
  logic [31:0] mem_q [DEPTH];

  // Address-phase capture
  logic        dp_valid_q, dp_valid_d;
  logic        dp_mem_q, dp_mem_d;
  logic        dp_write_q, dp_write_d;
  logic [20:0] dp_idx_q, dp_idx_d;
  logic [2:0]  dp_size_q, dp_size_d;
  logic [1:0]  dp_lo_q, dp_lo_d;

  // Memory read wait state
  logic        rd_phase_q, rd_phase_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic [BPP-1:0] colour_q, colour_d;

  // Fill engine
  state_e         state_q, state_d;
  logic [CW-1:0]  fill_cnt_q, fill_cnt_d;
  logic           done_q, done_d;
  logic [31:0]    fill_word_q, fill_word_d;

  // Video pipeline
  logic [AW-1:0]  vid_addr_q, vid_addr_d;
  logic [OW-1:0]  vid_off_q, vid_off_d;
  logic           vid_oor_q, vid_oor_d;
  logic [BPP-1:0] pixel_q, pixel_d;

  logic        busy;
  logic        addr_go;
  logic        dp_reg, dp_memx;
  logic        in_range;
  logic [3:0]  be;
  logic        mem_wr_go, mem_rd_issue;
  logic        start_req, clr_req;
  logic        hreadyout;
  logic [31:0] hrdata;

  logic        mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wbe;

  logic [31:0] vid_p;
  logic [31:0] vid_word;

  logic unused_haddr;
  assign unused_haddr = ^bus.HADDR[31:24];

  assign busy = (state_q == StFill);

  // ---------------------------------------------------------------------------
  // Address phase. Captured controls hold while HREADY is low (data phase stalled).
  // ---------------------------------------------------------------------------
  assign addr_go = bus.HSEL && bus.HREADY && (bus.HTRANS != 2'b00);

  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_mem_d   = dp_mem_q;
    dp_write_d = dp_write_q;
    dp_idx_d   = dp_idx_q;
    dp_size_d  = dp_size_q;
    dp_lo_d    = dp_lo_q;
    if (bus.HREADY) begin
      dp_valid_d = addr_go;
      dp_mem_d   = addr_go && bus.HADDR[23];
      dp_write_d = addr_go && bus.HWRITE;
      dp_idx_d   = addr_go ? bus.HADDR[22:2] : '0;
      dp_size_d  = addr_go ? bus.HSIZE : '0;
      dp_lo_d    = addr_go ? bus.HADDR[1:0] : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Data phase decode
  // ---------------------------------------------------------------------------
  assign dp_reg   = dp_valid_q && !dp_mem_q;
  assign dp_memx  = dp_valid_q && dp_mem_q;
  assign in_range = (32'(dp_idx_q) < DEPTH);

  always_comb begin
    case (dp_size_q)
      3'd0:    be = 4'b0001 << dp_lo_q;
      3'd1:    be = dp_lo_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Memory transfers wait for the fill to finish; reads add one wait state.
  assign mem_wr_go    = dp_memx && dp_write_q && !busy;
  assign mem_rd_issue = dp_memx && !dp_write_q && !busy && !rd_phase_q;
  assign hreadyout    = !(dp_memx && (busy || (!dp_write_q && !rd_phase_q)));
  assign rd_phase_d   = mem_rd_issue;
  assign rd_data_d    = (mem_rd_issue && in_range) ? mem_q[dp_idx_q[AW-1:0]] : '0;

  // Register writes act on byte lane 0 only; the writable fields all sit there.
  always_comb begin
    colour_d  = colour_q;
    start_req = 1'b0;
    clr_req   = 1'b0;
    if (dp_reg && dp_write_q && be[0]) begin
      unique case (dp_idx_q[1:0])
        2'd0: begin
          start_req = bus.HWDATA[0];
          clr_req   = bus.HWDATA[1];
        end
        2'd1:    colour_d = bus.HWDATA[BPP-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    hrdata = '0;
    if (dp_reg && !dp_write_q) begin
      unique case (dp_idx_q[1:0])
        2'd1:    hrdata = 32'(colour_q);
        2'd2:    hrdata = {30'b0, done_q, busy};
        2'd3:    hrdata = 32'(fill_cnt_q);
        default: hrdata = '0;
      endcase
    end else if (dp_memx && !dp_write_q && rd_phase_q) begin
      hrdata = rd_data_q;
    end
  end

  assign bus.HRDATA    = hrdata;
  assign bus.HREADYOUT = hreadyout;

  // ---------------------------------------------------------------------------
  // Fill engine next state. Completion is applied after the DONE clear so it wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    done_d      = done_q;
    fill_word_d = fill_word_q;
    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d     = StFill;
          fill_cnt_d  = '0;
          done_d      = 1'b0;
          fill_word_d = {PPW{colour_q}};
        end else if (clr_req) begin
          done_d = 1'b0;
        end
      end
      StFill: begin
        if (clr_req) done_d = 1'b0;
        if (fill_cnt_q == CW'(DEPTH - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      fill_cnt_q  <= '0;
      done_q      <= 1'b0;
      fill_word_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      done_q      <= done_d;
      fill_word_q <= fill_word_d;
    end
  end

  assign fill_busy = busy;

  // ---------------------------------------------------------------------------
  // Memory write port: the fill owns it while busy, AHB writes otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_wbe   = '0;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = fill_cnt_q[AW-1:0];
      mem_wdata = fill_word_q;
      mem_wbe   = 4'b1111;
    end else if (mem_wr_go && in_range) begin
      mem_we    = 1'b1;
      mem_waddr = dp_idx_q[AW-1:0];
      mem_wdata = bus.HWDATA;
      mem_wbe   = be;
    end
  end

  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wbe[b]) mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (mem_rd_issue) rd_data_q <= rd_data_d;
  end

  // ---------------------------------------------------------------------------
  // Video port: stage 1 address/offset, stage 2 read and lane select.
  // Out-of-range coordinates park the address at 0 to keep the read in bounds.
  // ---------------------------------------------------------------------------
  always_comb begin
    vid_p     = 32'(pixel_y) * H_RES + 32'(pixel_x);
    vid_oor_d = (32'(pixel_x) >= H_RES) || (32'(pixel_y) >= V_RES);
    vid_addr_d = vid_oor_d ? '0 : AW'(vid_p >> OW);
    vid_off_d  = vid_oor_d ? '0 : OW'(vid_p);
    vid_word   = mem_q[vid_addr_q];
    pixel_d    = vid_oor_q ? '0 : BPP'(vid_word >> (32'(vid_off_q) * BPP));
  end

  assign pixel = pixel_q;

  // ---------------------------------------------------------------------------
  // Bus capture, colour and video pipeline state
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_mem_q   <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      dp_size_q  <= '0;
      dp_lo_q    <= '0;
      rd_phase_q <= 1'b0;
      colour_q   <= '0;
      vid_addr_q <= '0;
      vid_off_q  <= '0;
      vid_oor_q  <= 1'b0;
      pixel_q    <= '0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_mem_q   <= dp_mem_d;
      dp_write_q <= dp_write_d;
      dp_idx_q   <= dp_idx_d;
      dp_size_q  <= dp_size_d;
      dp_lo_q    <= dp_lo_d;
      rd_phase_q <= rd_phase_d;
      colour_q   <= colour_d;
      vid_addr_q <= vid_addr_d;
      vid_off_q  <= vid_off_d;
      vid_oor_q  <= vid_oor_d;
      pixel_q    <= pixel_d;
    end
  end

endmodule
